axi_rd_arbiter: RTL and testbench

- Shares the single AXI read channel pair (AR/R) of the memory subsystem between two requesters: instruction-side (I) and data-side (D) refill/uncached reads.
- Sits inside the MMU/cache layer, between the I-cache and D-cache miss engines and the top-level AXI master read ports.
- Only one burst is outstanding at a time. The block handles arbitration, AR issue, and R-beat routing back to the owner.

---
 rtl/axi_rd_arbiter_if.sv | 69 ++++++
 rtl/axi_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_if
// Description : Requester-side and AXI read-channel bundle for axi_rd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rd_arbiter_if;
    // I-side requester
    logic        i_req;
    logic [31:0] i_addr;
    logic [7:0]  i_len;
    logic [2:0]  i_size;
    logic        i_gnt;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;
    logic        i_rerr;
    // D-side requester
    logic        d_req;
    logic [31:0] d_addr;
    logic [7:0]  d_len;
    logic [2:0]  d_size;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rlast;
    logic        d_rerr;
    // AXI AR channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    // AXI R channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  i_req, i_addr, i_len, i_size,
        output i_gnt, i_rdata, i_rvalid, i_rlast, i_rerr,
        input  d_req, d_addr, d_len, d_size,
        output d_gnt, d_rdata, d_rvalid, d_rlast, d_rerr,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output i_req, i_addr, i_len, i_size,
        input  i_gnt, i_rdata, i_rvalid, i_rlast, i_rerr,
        output d_req, d_addr, d_len, d_size,
        input  d_gnt, d_rdata, d_rvalid, d_rlast, d_rerr,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-requester (I/D) arbiter onto one AXI read channel, single
//               outstanding burst. Define AXI_RD_ARB_RR_EN for round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic               clk,
    input  logic               rst,
    axi_rd_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_owner;      // 1 = D side owns the current burst
    logic        r_arvalid;
    logic        r_rready;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;

    logic        w_any_req;
    logic        w_pick_d;
    logic        w_ar_hs;
    logic        w_r_end;
    logic        w_beat;
    logic        w_unused;

    assign w_any_req = bus.i_req | bus.d_req;
    assign w_ar_hs   = (r_state == ST_ADDR) & r_arvalid & bus.arready;
    assign w_r_end   = (r_state == ST_DATA) & bus.rvalid & bus.rlast;

`ifdef AXI_RD_ARB_RR_EN
    logic r_last_grant;        // 1 = D side was granted last

    // On contention take the side that was not granted last
    assign w_pick_d = bus.d_req & (~bus.i_req | ~r_last_grant);
`else
    assign w_pick_d = bus.d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_state_nxt = ST_ADDR;
            ST_ADDR: if (w_ar_hs)   w_state_nxt = ST_DATA;
            ST_DATA: if (w_r_end)   w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_arid    <= 4'd0;
            r_araddr  <= 32'd0;
            r_arlen   <= 8'd0;
            r_arsize  <= 3'd0;
`ifdef AXI_RD_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick_d;
                        r_arvalid <= 1'b1;
                        r_arid    <= w_pick_d ? ID_DATA   : ID_INST;
                        r_araddr  <= w_pick_d ? bus.d_addr : bus.i_addr;
                        r_arlen   <= w_pick_d ? bus.d_len  : bus.i_len;
                        r_arsize  <= w_pick_d ? bus.d_size : bus.i_size;
                    end
                end
                ST_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
`ifdef AXI_RD_ARB_RR_EN
                        r_last_grant <= r_owner;
`endif
                    end
                end
                ST_DATA: begin
                    if (w_r_end) r_rready <= 1'b0;
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arid    = r_arid;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = r_arlen;
    assign bus.arsize  = r_arsize;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = r_rready;

    // Grant is a same-cycle pulse off the AR handshake
    assign bus.i_gnt = w_ar_hs & ~r_owner;
    assign bus.d_gnt = w_ar_hs &  r_owner;

    assign w_beat = bus.rvalid & r_rready;

    assign bus.i_rdata  = bus.rdata;
    assign bus.d_rdata  = bus.rdata;
    assign bus.i_rvalid = w_beat & ~r_owner;
    assign bus.d_rvalid = w_beat &  r_owner;
    assign bus.i_rlast  = w_beat & ~r_owner & bus.rlast;
    assign bus.d_rlast  = w_beat &  r_owner & bus.rlast;
    assign bus.i_rerr   = w_beat & ~r_owner & (bus.rresp != 2'b00);
    assign bus.d_rerr   = w_beat &  r_owner & (bus.rresp != 2'b00);

    // Only one burst is ever in flight, so the returned ID carries no information
    assign w_unused = ^bus.rid;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed self-checking bench for axi_rd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_rd_arbiter_if bus ();

    axi_rd_arbiter #(
        .ID_INST (4'd0),
        .ID_DATA (4'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 32'd0; bus.i_len = 8'd0; bus.i_size = 3'd0;
        bus.d_req = 1'b0; bus.d_addr = 32'd0; bus.d_len = 8'd0; bus.d_size = 3'd0;
        bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata = 32'd0;
        bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready",  bus.rready, 0);
        check("rst_araddr",  bus.araddr, 0);
        check("rst_arid",    bus.arid, 0);
        check("rst_arlen",   bus.arlen, 0);
        check("rst_gnt",     {bus.i_gnt, bus.d_gnt}, 0);
        check("rst_rvalid",  {bus.i_rvalid, bus.d_rvalid}, 0);
    endtask

    // Entered at a negedge with the arbiter in ADDR for the given side
    task automatic ar_phase(input bit side_d, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int stall);
        for (int c = 0; c < stall; c++) begin
            #1;
            check("stall_arvalid", bus.arvalid, 1);
            check("stall_araddr",  bus.araddr, addr);
            check("stall_gnt",     {bus.i_gnt, bus.d_gnt}, 0);
            @(negedge clk);
        end
        bus.arready = 1'b1;
        #1;
        check("ar_arvalid", bus.arvalid, 1);
        check("ar_araddr",  bus.araddr, addr);
        check("ar_arid",    bus.arid, side_d ? 32'd1 : 32'd0);
        check("ar_arlen",   bus.arlen, len);
        check("ar_arsize",  bus.arsize, size);
        check("ar_arburst", bus.arburst, 32'd1);
        check("ar_gnt",     {bus.i_gnt, bus.d_gnt}, side_d ? 32'd1 : 32'd2);
        check("ar_rready",  bus.rready, 0);
        @(negedge clk);
        bus.arready = 1'b0;
        if (side_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        #1;
        check("post_ar_arvalid", bus.arvalid, 0);
        check("post_ar_rready",  bus.rready, 1);
        check("post_ar_gnt",     {bus.i_gnt, bus.d_gnt}, 0);
    endtask

    task automatic burst(input bit side_d, input int beats, input int gap, input int err_beat);
        logic own_v, own_l, own_e, oth_v;
        for (int b = 0; b < beats; b++) begin
            for (int g = 0; g < gap && b > 0; g++) begin
                bus.rvalid = 1'b0;
                #1;
                check("gap_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
                check("gap_rready", bus.rready, 1);
                @(negedge clk);
            end
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hA500_0000 | b;
            bus.rlast  = (b == beats - 1);
            bus.rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            #1;
            own_v = side_d ? bus.d_rvalid : bus.i_rvalid;
            own_l = side_d ? bus.d_rlast  : bus.i_rlast;
            own_e = side_d ? bus.d_rerr   : bus.i_rerr;
            oth_v = side_d ? bus.i_rvalid : bus.d_rvalid;
            check("beat_rvalid", own_v, 1);
            check("beat_rlast",  own_l, (b == beats - 1));
            check("beat_rerr",   own_e, (b == err_beat));
            check("beat_rdata",  side_d ? bus.d_rdata : bus.i_rdata, 32'hA500_0000 | b);
            check("beat_other",  oth_v, 0);
            @(negedge clk);
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit first_d;

        // Single I-side 8-beat burst, arready after 2 cycles
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0000; bus.i_len = 8'd7; bus.i_size = 3'd2;
        @(negedge clk);
        ar_phase(1'b0, 32'hBFC0_0000, 8'd7, 3'd2, 2);
        burst(1'b0, 8, 0, -1);
        #1;
        check("i_done_rready",  bus.rready, 0);
        check("i_done_arvalid", bus.arvalid, 0);
        @(negedge clk);
        #1;
        check("i_idle_arvalid", bus.arvalid, 0);

        // D-side: AR stall of 5, 3-cycle gaps, error on beat 2 of 4
        bus.d_req = 1'b1; bus.d_addr = 32'h8000_2000; bus.d_len = 8'd3; bus.d_size = 3'd2;
        @(negedge clk);
        ar_phase(1'b1, 32'h8000_2000, 8'd3, 3'd2, 5);
        burst(1'b1, 4, 3, 1);
        #1;
        check("d_done_rready", bus.rready, 0);

        // Back-to-back D requests, len=0
        bus.d_req = 1'b1; bus.d_addr = 32'h8000_3000; bus.d_len = 8'd0;
        @(negedge clk);
        ar_phase(1'b1, 32'h8000_3000, 8'd0, 3'd2, 0);
        bus.rvalid = 1'b1; bus.rlast = 1'b1; bus.rdata = 32'h1234_5678;
        bus.d_req = 1'b1; bus.d_addr = 32'h8000_4000;
        #1;
        check("b2b_rlast", bus.d_rlast, 1);
        @(negedge clk);
        bus.rvalid = 1'b0; bus.rlast = 1'b0;
        #1;
        check("b2b_gap_arvalid", bus.arvalid, 0);
        check("b2b_gap_rready",  bus.rready, 0);
        @(negedge clk);
        #1;
        check("b2b_arvalid", bus.arvalid, 1);
        check("b2b_araddr",  bus.araddr, 32'h8000_4000);
        check("b2b_overlap", bus.rready, 0);
        ar_phase(1'b1, 32'h8000_4000, 8'd0, 3'd2, 0);
        burst(1'b1, 1, 0, -1);

        // Simultaneous I and D requests straight after reset
        do_reset();
`ifdef AXI_RD_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0040; bus.i_len = 8'd0; bus.i_size = 3'd2;
        bus.d_req = 1'b1; bus.d_addr = 32'h8000_1000; bus.d_len = 8'd0; bus.d_size = 3'd2;
        @(negedge clk);
        ar_phase(first_d, first_d ? 32'h8000_1000 : 32'hBFC0_0040, 8'd0, 3'd2, 1);
        burst(first_d, 1, 0, -1);
        #1;
        check("sim_gap_arvalid", bus.arvalid, 0);
        @(negedge clk);
        ar_phase(!first_d, first_d ? 32'hBFC0_0040 : 32'h8000_1000, 8'd0, 3'd2, 0);
        burst(!first_d, 1, 0, -1);

        // Reset in the middle of a DATA phase, then a fresh request
        bus.i_req = 1'b1; bus.i_addr = 32'hBFC0_0080; bus.i_len = 8'd3;
        @(negedge clk);
        ar_phase(1'b0, 32'hBFC0_0080, 8'd3, 3'd2, 0);
        bus.rvalid = 1'b1; bus.rlast = 1'b0; bus.rdata = 32'hCAFE_0001;
        #1;
        check("mid_beat1", bus.i_rvalid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_arvalid", bus.arvalid, 0);
        check("mid_rready",  bus.rready, 0);
        check("mid_rvalid",  {bus.i_rvalid, bus.d_rvalid}, 0);
        bus.rvalid = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h8000_5000; bus.d_len = 8'd1;
        @(negedge clk);
        ar_phase(1'b1, 32'h8000_5000, 8'd1, 3'd2, 0);
        burst(1'b1, 2, 0, -1);
        #1;
        check("fresh_done_rready", bus.rready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
